circ_buffer_ctrl: RTL and testbench
===================================

# circ_buffer_ctrl

Pointer and flow-control stage sitting directly upstream of the K-in/J-out parallel `Buffer`. Accepts K-word write bursts and J-word read requests over valid/ready handshakes, keeps write/read pointers that wrap modulo SIZE, and tracks occupancy. Drives the buffer's `ld`, `write_add` and `read_add`, so the buffer operates as a circular FIFO with no external address management.

## Interface
- `SIZE`, 16: buffer depth in words; power of two, ≥ 2
- `K`, 8: words per write burst; 1 ≤ K ≤ SIZE
- `J`, 4: words per read burst; 1 ≤ J ≤ SIZE
- `BIT`, $clog2(SIZE): address width (derived)
- `CW`, $clog2(SIZE+1): occupancy width (derived)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_valid`  in  1  upstream presents K words on the buffer's `par_in`
- `wr_ready`  out  1  at least K free entries
- `rd_ready`  in  1  downstream consumes J words from the buffer's `par_out` this cycle
- `rd_valid`  out  1  at least J stored entries
- `ld`  out  1  buffer write strobe
- `write_add`  out  BIT  buffer write base address
- `read_add`  out  BIT  buffer read base address
- `count`  out  CW  stored words, 0..SIZE
- `full`  out  1  count == SIZE
- `empty`  out  1  count == 0
- `err`  out  1  sticky protocol error (see Configuration)

## Operation
- State: `wr_ptr`, `rd_ptr` (BIT bits), `cnt` (CW bits), `err_q`. No FSM; status outputs are decoded from `cnt`.
- `wr_ready = (cnt <= SIZE-K)`; `rd_valid = (cnt >= J)`; both depend only on registered `cnt`, never on same-cycle inputs.
- Write handshake `wr_fire = wr_valid & wr_ready`; `ld = wr_fire`, combinational.
- Read handshake `rd_fire = rd_ready & rd_valid`.
- On `wr_fire`: `wr_ptr <= (wr_ptr + K) mod SIZE`. The buffer stores entries write_add..write_add+K-1 mod SIZE.
- On `rd_fire`: `rd_ptr <= (rd_ptr + J) mod SIZE`.
- `cnt <= cnt + (wr_fire ? K : 0) - (rd_fire ? J : 0)`, computed in CW+1 bits. Simultaneous fire is legal and yields a net change of K-J.
- Mod-SIZE wrap: truncate to BIT bits. No special-case code.
- Words written in cycle n are not readable before cycle n+1; there is no write-to-read bypass.
- `wr_valid` while `!wr_ready`: ignored, with no pointer or count change. `rd_ready` while `!rd_valid`: ignored likewise.

## Timing
- Reset (`rst`=0, asynchronous): `wr_ptr`=0, `rd_ptr`=0, `cnt`=0, `err_q`=0. Resulting outputs: `write_add`=0, `read_add`=0, `count`=0, `empty`=1, `full`=0, `wr_ready`=1 (given K ≤ SIZE), `rd_valid`=0, `ld`=0, `err`=0.
- Reset asserted mid-burst: all state clears immediately. Buffer contents are not cleared but are considered invalid.
- Reset release is synchronised by the integrator. The block takes no action on the release edge.
- `ld` and `write_add` are valid in the same cycle as `wr_fire`; the buffer captures on that rising edge.
- `read_add` is valid whenever `rd_valid`=1; `par_out` is combinational from it.
- Pointers and `count` update one edge after a fire. Full throughput is one write and one read per cycle.

## Configuration
- Macro `CIRC_BUF_CTRL_ERR_EN`.
- Defined: `err_q` is set on any clock edge where `wr_valid & !wr_ready` or `rd_ready & !rd_valid` holds. It stays set until reset. `err = err_q`.
- Undefined: no `err_q` flop; `err` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `buf_pkg`: default SIZE/K/WIDTH/J values, the `BIT`/`CW` width functions, and the config-legality check (power-of-two SIZE, K ≤ SIZE, J ≤ SIZE). The same package is used by `Buffer`.
- Sub-module `wrap_ptr`: a BIT-wide register with an enable and a constant step. It advances mod SIZE and resets asynchronously to 0. It is instantiated twice (step K, step J).

## Test plan
All scenarios use SIZE=16, K=8, J=4.
- Reset: pulse `rst` low mid-cycle -> immediately `write_add`=0, `read_add`=0, `count`=0, `empty`=1, `wr_ready`=1, `rd_valid`=0.
- Fill: two consecutive `wr_valid` cycles -> `count` 8 then 16, `write_add` 0→8→0 (wrap), `full`=1, `wr_ready`=0. A third write is ignored and `count` stays 16.
- Drain: from full, hold `rd_ready` for 4 cycles -> `read_add` 0,4,8,12, then 0; `count` 12,8,4,0; `empty`=1; `rd_valid`=0.
- Simultaneous fire: at `count`=8, `read_add`=0, `write_add`=8, assert both handshakes -> `count`=12, `write_add`=0, `read_add`=4.
- Error (macro defined): `rd_ready`=1 while `count`=0 -> `err`=1, and it stays 1 after the cycle. With the macro undefined -> `err`=0.
- Reset mid-operation: at `count`=12, assert `rst` together with `wr_valid` -> all state returns to reset values and no `ld` is issued.

Source files
------------

// File: rtl/buf_pkg.sv
// buf_pkg: shared configuration for the circular Buffer and its controller.
//   Default geometry (SIZE/K/J/WIDTH), address and occupancy width helpers,
//   and the configuration legality check used at elaboration time.
package buf_pkg;

    localparam int SIZE_DEF  = 16;
    localparam int K_DEF     = 8;
    localparam int J_DEF     = 4;
    localparam int WIDTH_DEF = 8;

    // Address width for a SIZE-deep buffer.
    function automatic int addr_bits(input int size);
        return $clog2(size);
    endfunction

    // Occupancy width: must represent 0..SIZE inclusive.
    function automatic int cnt_bits(input int size);
        return $clog2(size + 1);
    endfunction

    // Power-of-two SIZE >= 2, 1 <= K <= SIZE, 1 <= J <= SIZE.
    function automatic bit cfg_ok(input int size, input int k, input int j);
        return (size >= 2) && ((size & (size - 1)) == 0) &&
               (k >= 1) && (k <= size) && (j >= 1) && (j <= size);
    endfunction

endpackage

// File: rtl/circ_buffer_ctrl_wrap_ptr.sv
// wrap_ptr: BIT-wide pointer register that advances by a constant STEP
//   modulo SIZE when en is high; asynchronous active-low reset to 0.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   en   - advance this cycle
//   ptr  - current pointer value
module wrap_ptr #(
    parameter int SIZE = 16,
    parameter int STEP = 1,
    parameter int BIT  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [BIT-1:0] ptr
);

    // SIZE is a power of two, so truncation to BIT bits is the modulo.
    localparam logic [BIT-1:0] STEP_W = BIT'(STEP % SIZE);

    logic [BIT-1:0] ptr_q;
    logic [BIT-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) ptr_d = ptr_q + STEP_W;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/circ_buffer_ctrl.sv
// circ_buffer_ctrl: pointer and flow-control stage for the K-in/J-out
//   parallel Buffer, making it behave as a circular FIFO.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   wr_valid / wr_ready - K-word write burst handshake
//   rd_ready / rd_valid - J-word read burst handshake
//   ld, write_add       - buffer write strobe and write base address
//   read_add            - buffer read base address
//   count, full, empty  - occupancy and its decodes
//   err                 - sticky protocol error
// Optional feature: define CIRC_BUF_CTRL_ERR_EN to enable the sticky err flop;
//   otherwise err is tied low.
module circ_buffer_ctrl
    import buf_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int K    = K_DEF,
    parameter int J    = J_DEF,
    parameter int BIT  = addr_bits(SIZE),
    parameter int CW   = cnt_bits(SIZE)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic           rd_ready,
    output logic           rd_valid,
    output logic           ld,
    output logic [BIT-1:0] write_add,
    output logic [BIT-1:0] read_add,
    output logic [CW-1:0]  count,
    output logic           full,
    output logic           empty,
    output logic           err
);

    if (!cfg_ok(SIZE, K, J)) begin : g_bad_cfg
        $error("circ_buffer_ctrl: illegal SIZE/K/J configuration");
    end

    localparam logic [CW:0] K_W = (CW+1)'(K);
    localparam logic [CW:0] J_W = (CW+1)'(J);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   cnt_sum;
    logic          wr_fire;
    logic          rd_fire;

    // Handshake readiness depends only on registered occupancy.
    assign wr_ready = (cnt_q <= CW'(SIZE - K));
    assign rd_valid = (cnt_q >= CW'(J));

    // The strobe is gated by reset so a write presented while reset is held
    // never reaches the buffer, even though wr_ready reads 1 at count 0.
    assign wr_fire = wr_valid & wr_ready & rst;
    assign rd_fire = rd_ready & rd_valid;
    assign ld      = wr_fire;

    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        if (wr_fire) cnt_sum = cnt_sum + K_W;
        if (rd_fire) cnt_sum = cnt_sum - J_W;
        cnt_d = cnt_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    wrap_ptr #(.SIZE(SIZE), .STEP(K), .BIT(BIT)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_fire),
        .ptr (write_add)
    );

    wrap_ptr #(.SIZE(SIZE), .STEP(J), .BIT(BIT)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_fire),
        .ptr (read_add)
    );

    assign count = cnt_q;
    assign full  = (cnt_q == CW'(SIZE));
    assign empty = (cnt_q == '0);

`ifdef CIRC_BUF_CTRL_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q | (wr_valid & ~wr_ready) | (rd_ready & ~rd_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_circ_buffer_ctrl.sv
module tb_circ_buffer_ctrl;

    localparam int SIZE = 16;
    localparam int K    = 8;
    localparam int J    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       rd_ready = 1'b0;
    logic       wr_ready, rd_valid, ld, full, empty, err;
    logic [3:0] write_add, read_add;
    logic [4:0] count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: occupancy and pointers as plain integers.
    int m_count = 0;
    int m_wp    = 0;
    int m_rp    = 0;
    bit m_err   = 1'b0;

    always #5 clk = ~clk;

    circ_buffer_ctrl #(.SIZE(SIZE), .K(K), .J(J)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .ld        (ld),
        .write_add (write_add),
        .read_add  (read_add),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    function automatic bit m_wr_ready();
        return (SIZE - m_count) >= K;
    endfunction

    function automatic bit m_rd_valid();
        return m_count >= J;
    endfunction

    function automatic bit m_ld();
        return wr_valid && m_wr_ready() && rst;
    endfunction

    task automatic model_reset();
        m_count = 0; m_wp = 0; m_rp = 0; m_err = 1'b0;
    endtask

    // Drive inputs just after a falling edge; combinational outputs settle by #1.
    task automatic drive(input bit wv, input bit rr);
        @(negedge clk);
        wr_valid = wv;
        rd_ready = rr;
        #1;
    endtask

    // Advance one rising edge and update the model; registered outputs settle by #1.
    task automatic tick();
        bit wf, rf;
        @(posedge clk);
        if (rst) begin
            wf = wr_valid && m_wr_ready();
            rf = rd_ready && m_rd_valid();
`ifdef CIRC_BUF_CTRL_ERR_EN
            if ((wr_valid && !m_wr_ready()) || (rd_ready && !m_rd_valid())) m_err = 1'b1;
`endif
            if (wf) begin m_count += K; m_wp = (m_wp + K) % SIZE; end
            if (rf) begin m_count -= J; m_rp = (m_rp + J) % SIZE; end
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 0);
        tick();
        n_vec++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL reset_pre_count got %0d want %0d", count, m_count); end
        // Pull reset mid-cycle; outputs must clear without waiting for an edge.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++; if (write_add !== 4'd0) begin n_err++; $display("FAIL reset_write_add got %0d want 0", write_add); end
        n_vec++; if (read_add !== 4'd0) begin n_err++; $display("FAIL reset_read_add got %0d want 0", read_add); end
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        wr_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_fill();
        int exp_cnt [2] = '{8, 16};
        int exp_wa  [2] = '{8, 0};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0);
            n_vec++; if (ld !== 1'b1) begin n_err++; $display("FAIL fill_ld[%0d] got %b want 1", i, ld); end
            tick();
            n_vec++; if (count !== 5'(exp_cnt[i])) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, exp_cnt[i]); end
            n_vec++; if (write_add !== 4'(exp_wa[i])) begin n_err++; $display("FAIL fill_write_add[%0d] got %0d want %0d", i, write_add, exp_wa[i]); end
        end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_wr_ready got %b want 0", wr_ready); end
        drive(1, 0);
        n_vec++; if (ld !== 1'b0) begin n_err++; $display("FAIL fill_third_ld got %b want 0", ld); end
        tick();
        n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_third_count got %0d want 16", count); end
        n_vec++; if (write_add !== 4'd0) begin n_err++; $display("FAIL fill_third_write_add got %0d want 0", write_add); end
        drive(0, 0);
    endtask

    task automatic test_drain();
        int exp_ra  [4] = '{0, 4, 8, 12};
        int exp_cnt [4] = '{12, 8, 4, 0};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1);
            n_vec++; if (read_add !== 4'(exp_ra[i])) begin n_err++; $display("FAIL drain_read_add[%0d] got %0d want %0d", i, read_add, exp_ra[i]); end
            tick();
            n_vec++; if (count !== 5'(exp_cnt[i])) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, exp_cnt[i]); end
        end
        n_vec++; if (read_add !== 4'd0) begin n_err++; $display("FAIL drain_read_add_wrap got %0d want 0", read_add); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_rd_valid got %b want 0", rd_valid); end
        drive(0, 0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1, 0);
        tick();
        drive(1, 1);
        n_vec++; if ({count, write_add, read_add} !== {5'd8, 4'd8, 4'd0}) begin n_err++; $display("FAIL sim_setup got cnt=%0d wa=%0d ra=%0d want 8/8/0", count, write_add, read_add); end
        tick();
        n_vec++; if (count !== 5'd12) begin n_err++; $display("FAIL sim_count got %0d want 12", count); end
        n_vec++; if (write_add !== 4'd0) begin n_err++; $display("FAIL sim_write_add got %0d want 0", write_add); end
        n_vec++; if (read_add !== 4'd4) begin n_err++; $display("FAIL sim_read_add got %0d want 4", read_add); end
        drive(0, 0);
    endtask

    task automatic test_error();
        bit want;
`ifdef CIRC_BUF_CTRL_ERR_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        do_reset();
        drive(0, 1);
        tick();
        n_vec++; if (err !== want) begin n_err++; $display("FAIL err_set got %b want %b", err, want); end
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL err_count got %0d want 0", count); end
        drive(0, 0);
        tick();
        n_vec++; if (err !== want) begin n_err++; $display("FAIL err_sticky got %b want %b", err, want); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0); tick();
        drive(1, 0); tick();
        drive(0, 1); tick();
        n_vec++; if (count !== 5'd12) begin n_err++; $display("FAIL rstmid_setup got %0d want 12", count); end
        @(negedge clk);
        wr_valid = 1'b1;
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++; if (ld !== 1'b0) begin n_err++; $display("FAIL rstmid_ld got %b want 0", ld); end
        @(posedge clk);
        #1;
        n_vec++; if (ld !== 1'b0) begin n_err++; $display("FAIL rstmid_ld_edge got %b want 0", ld); end
        n_vec++; if ({count, write_add, read_add, empty} !== {5'd0, 4'd0, 4'd0, 1'b1}) begin n_err++; $display("FAIL rstmid_state got cnt=%0d wa=%0d ra=%0d empty=%b want 0/0/0/1", count, write_add, read_add, empty); end
        @(negedge clk);
        wr_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_vec++; if (ld !== m_ld()) begin n_err++; $display("FAIL rnd_ld[%0d] got %b want %b", i, ld, m_ld()); end
            n_vec++; if (wr_ready !== m_wr_ready()) begin n_err++; $display("FAIL rnd_wr_ready[%0d] got %b want %b", i, wr_ready, m_wr_ready()); end
            n_vec++; if (rd_valid !== m_rd_valid()) begin n_err++; $display("FAIL rnd_rd_valid[%0d] got %b want %b", i, rd_valid, m_rd_valid()); end
            tick();
            n_vec++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, m_count); end
            n_vec++; if (write_add !== 4'(m_wp)) begin n_err++; $display("FAIL rnd_write_add[%0d] got %0d want %0d", i, write_add, m_wp); end
            n_vec++; if (read_add !== 4'(m_rp)) begin n_err++; $display("FAIL rnd_read_add[%0d] got %0d want %0d", i, read_add, m_rp); end
            n_vec++; if (full !== (m_count == SIZE)) begin n_err++; $display("FAIL rnd_full[%0d] got %b want %b", i, full, m_count == SIZE); end
            n_vec++; if (empty !== (m_count == 0)) begin n_err++; $display("FAIL rnd_empty[%0d] got %b want %b", i, empty, m_count == 0); end
            n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d] got %b want %b", i, err, m_err); end
        end
        drive(0, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout reached, got still running want finished");
        $fatal(1, "timeout");
    end

endmodule
